prog_test_engine: RTL
=====================

Name: prog_test_engine

Overview:
- Generalised successor to the per-test generated FPGA harnesses.
- Executes a small loadable instruction program rather than a hard-coded case statement.
- Supports parametrised word width, local memory, output channel and program depth.
- Streams outputs over a valid/ready port and compares them against a loaded expected-output table to drive finished/success.

Parameters:
- MemoryElementWidth, 12: data width W of local memory, outputs and immediates.
- NLocal, 8: local memory words; power of two; LA = clog2(NLocal).
- NOut, 4: output channel depth and expected-table depth.
- NProg, 32: program memory depth; PA = clog2(NProg); PA <= W required.
- MaxSteps, 1024: watchdog step limit.

Ports:
- clock  in  1  driving clock.
- reset  in  1  asynchronous, active-high reset.
- prog_we  in  1  program write strobe; honoured in IDLE only.
- prog_addr  in  PA  program write address.
- prog_data  in  4+2*LA+W  instruction word {op, a, b, imm}.
- exp_we  in  1  expected-output write strobe; honoured in IDLE only.
- exp_addr  in  clog2(NOut)  expected-table address.
- exp_data  in  W  expected value.
- exp_count  in  clog2(NOut)+1  number of outputs expected; sampled at start.
- start  in  1  begins a run from ip=0; honoured in IDLE or DONE.
- out_data  out  W  streamed output value.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accept.
- finished  out  1  high in DONE.
- success  out  1  high in DONE when the run passed.
- error  out  2  0 none, 1 timeout, 2 output overflow, 3 illegal opcode.
- steps  out  32  instructions executed in the current run.

Behaviour:
- Reset (async): state IDLE; finished, success, out_valid and error = 0; steps = 0; ip = 0; outPos = 0.
- Reset does not clear program, expected-table or local memory contents.
- States:
  - IDLE -start-> RUN.
  - RUN -halt/ip>=NProg/error-> DONE.
  - DONE -start-> RUN.
- On start: ip = 0, steps = 0, outPos = 0, error = 0, finished = 0, success = 0, and the mismatch flag is cleared. Local memory is not cleared.
- RUN: one instruction per cycle; program memory is read combinationally at ip; steps increments per executed instruction.
- Opcodes:
  - 0 nop/label: ip+1.
  - 1 movI: L[a] = imm.
  - 2 mov: L[a] = L[b].
  - 3 add: L[a] = L[a] + L[b], modulo 2^W.
  - 4 sub: L[a] = L[a] - L[b], modulo 2^W.
  - 5 out: emit L[a].
  - 6 outI: emit imm.
  - 7 jmp: ip = imm[PA-1:0].
  - 8 jEq: branch if L[a] == L[b], else ip+1.
  - 9 jNe: branch if L[a] != L[b], else ip+1.
  - 10 jLt: branch if L[a] < L[b] (unsigned), else ip+1.
  - 11 jGe: branch if L[a] >= L[b] (unsigned), else ip+1.
  - 15 halt: go to DONE.
  - 12-14: illegal; error = 3, go to DONE.
- Emit:
  - If out_valid && !out_ready: stall. No state change, steps not incremented.
  - Otherwise: out_data = value, out_valid = 1, and the value is compared against exp[outPos].
  - A mismatch sets a sticky mismatch flag; outPos increments.
- Emit with outPos == NOut: error = 2, go to DONE, nothing emitted.
- out_valid clears on out_valid && out_ready unless a new emit occurs in the same cycle.
- ip reaching NProg, or a branch target >= NProg, is a normal finish.
- Watchdog: if steps == MaxSteps at the start of a RUN cycle, error = 1 and go to DONE.
- Entering DONE:
  - finished = 1.
  - success = (error == 0) && !mismatch && (outPos == exp_count).
  - Both are registered on the same edge as the DONE transition.
- A pending out_valid in DONE still completes its handshake.
- start in RUN is ignored. prog_we and exp_we outside IDLE are ignored.
- start and prog_we asserted together in IDLE: the write commits and the run begins next cycle.

Optional Feature:
- BRANCH_STATS_EN defined:
  - Adds output port branches_taken (32 bits).
  - It counts taken conditional branches plus jmp in the current run; cleared on reset and on start.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package prog_test_pkg holds:
  - opcode enum op_t (NOP, MOVI, MOV, ADD, SUB, OUT, OUTI, JMP, JEQ, JNE, JLT, JGE, HALT);
  - error codes ERR_NONE, ERR_TIMEOUT, ERR_OVERFLOW, ERR_ILLEGAL;
  - state enum IDLE, RUN, DONE.
- Sub-module prog_test_branch_unit: combinational compare of L[a] and L[b] per opcode, producing next-ip and taken.

Test Plan:
- Load movI L0=1; movI L1=2; jEq L0,L1->7; outI 111; jEq L0,L0->7; outI 999; nop; outI 333; halt; exp={111,333}, exp_count=2; out_ready=1 -> outputs 111 then 333, finished=1, success=1, error=0, steps=7.
- Same program with exp={111,334} -> finished=1, success=0, error=0.
- Program jmp 0 only, MaxSteps=16 -> DONE after 16 steps, error=1, success=0.
- outI 5 five times with NOut=4 -> fifth emit gives error=2, four values streamed.
- Two consecutive outI with out_ready held low 3 cycles -> engine stalls, steps frozen, values 7 then 8 delivered in order once ready rises.
- Assert reset mid-run -> immediately IDLE with finished=0 and out_valid=0; new start reruns the program to success=1.

Source files
------------

// File: rtl/prog_test_pkg.sv
// Shared opcode, error-code and state definitions for the programmable test engine.
package prog_test_pkg;

   typedef enum logic [3:0] {
      NOP  = 4'd0,
      MOVI = 4'd1,
      MOV  = 4'd2,
      ADD  = 4'd3,
      SUB  = 4'd4,
      OUT  = 4'd5,
      OUTI = 4'd6,
      JMP  = 4'd7,
      JEQ  = 4'd8,
      JNE  = 4'd9,
      JLT  = 4'd10,
      JGE  = 4'd11,
      HALT = 4'd15
   } op_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
   localparam logic [1:0] ERR_OVERFLOW = 2'd2;
   localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic is_emit(input logic [3:0] op);
      return (op == OUT) || (op == OUTI);
   endfunction

endpackage

// File: rtl/prog_test_branch_unit.sv
// Combinational next-ip selection: compares two local words for the conditional jumps,
// takes jmp unconditionally, and otherwise falls through to ip+1.
module prog_test_branch_unit
   import prog_test_pkg::*;
#(
   parameter int W  = 12,
   parameter int PA = 5
) (
   input  logic [3:0]  op,
   input  logic [W-1:0] va,
   input  logic [W-1:0] vb,
   input  logic [PA-1:0] target,
   input  logic [PA:0]  ip,
   output logic [PA:0]  next_ip,
   output logic         taken
);

   always_comb begin
      // NOTE: default every output of a combinational block first so no latch is inferred.
      taken = 1'b0;
      case (op)
         JMP:     taken = 1'b1;
         JEQ:     taken = (va == vb);
         JNE:     taken = (va != vb);
         JLT:     taken = (va < vb);
         JGE:     taken = (va >= vb);
         default: taken = 1'b0;
      endcase
      next_ip = taken ? {1'b0, target} : ip + 1'b1;
   end

endmodule

// File: rtl/prog_test_engine.sv
// Loadable-program test engine: runs a small instruction program, streams outputs over valid/ready
// and checks them against an expected table. Define BRANCH_STATS_EN to add the branches_taken counter.
module prog_test_engine
   import prog_test_pkg::*;
#(
   parameter int MemoryElementWidth = 12,
   parameter int NLocal   = 8,
   parameter int NOut     = 4,
   parameter int NProg    = 32,
   parameter int MaxSteps = 1024,
   localparam int W  = MemoryElementWidth,
   localparam int LA = $clog2(NLocal),
   localparam int PA = $clog2(NProg),
   localparam int OA = $clog2(NOut),
   localparam int IW = 4 + 2*LA + W
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          prog_we,
   input  logic [PA-1:0] prog_addr,
   input  logic [IW-1:0] prog_data,
   input  logic          exp_we,
   input  logic [OA-1:0] exp_addr,
   input  logic [W-1:0]  exp_data,
   input  logic [OA:0]   exp_count,
   input  logic          start,
   output logic [W-1:0]  out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          finished,
   output logic          success,
   output logic [1:0]    error,
   output logic [31:0]   steps
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]   branches_taken
`endif
);

   logic [IW-1:0] prog_mem [NProg];
   logic [W-1:0]  exp_mem  [NOut];
   logic [W-1:0]  lmem     [NLocal];

   state_t        state;
   logic [PA:0]   ip;
   logic [OA:0]   outpos;
   logic [OA:0]   exp_count_q;
   logic          mismatch;

   logic [IW-1:0] instr;
   logic [3:0]    op;
   logic [LA-1:0] fa, fb;
   logic [W-1:0]  imm, va, vb;
   logic [PA:0]   bu_next;
   logic          bu_taken;

   assign instr = prog_mem[ip[PA-1:0]];
   assign op    = instr[IW-1 -: 4];
   assign fa    = instr[2*LA+W-1 -: LA];
   assign fb    = instr[LA+W-1 -: LA];
   assign imm   = instr[W-1:0];
   assign va    = lmem[fa];
   assign vb    = lmem[fb];

   prog_test_branch_unit #(.W(W), .PA(PA)) u_branch (
      .op      (op),
      .va      (va),
      .vb      (vb),
      .target  (imm[PA-1:0]),
      .ip      (ip),
      .next_ip (bu_next),
      .taken   (bu_taken)
   );

   logic          go_done, stepped, fire, lmem_we, mismatch_n;
   logic [1:0]    err_n;
   logic [W-1:0]  emit_val, wdata;
   logic [PA:0]   ip_n;
   logic [OA:0]   outpos_n;

   always_comb begin
      go_done  = 1'b0;
      err_n    = ERR_NONE;
      stepped  = 1'b0;
      fire     = 1'b0;
      lmem_we  = 1'b0;
      ip_n     = ip;
      emit_val = (op == OUT) ? va : imm;
      wdata    = (op == MOVI) ? imm :
                 (op == MOV)  ? vb  :
                 (op == ADD)  ? va + vb : va - vb;
      if (state == RUN) begin
         if (steps == 32'(MaxSteps)) begin
            go_done = 1'b1;
            err_n   = ERR_TIMEOUT;
         end else if (is_emit(op)) begin
            // A still-unaccepted output freezes the whole engine, step count included.
            if (!(out_valid && !out_ready)) begin
               stepped = 1'b1;
               if (outpos == (OA+1)'(NOut)) begin
                  go_done = 1'b1;
                  err_n   = ERR_OVERFLOW;
               end else begin
                  fire = 1'b1;
                  ip_n = bu_next;
               end
            end
         end else begin
            stepped = 1'b1;
            case (op)
               HALT:                         go_done = 1'b1;
               NOP, JMP, JEQ, JNE, JLT, JGE: ip_n = bu_next;
               MOVI, MOV, ADD, SUB: begin
                  ip_n    = bu_next;
                  lmem_we = 1'b1;
               end
               default: begin
                  go_done = 1'b1;
                  err_n   = ERR_ILLEGAL;
               end
            endcase
         end
         if (stepped && !go_done && ip_n >= (PA+1)'(NProg))
            go_done = 1'b1;
      end
      mismatch_n = mismatch | (fire && (emit_val != exp_mem[outpos[OA-1:0]]));
      outpos_n   = outpos + (OA+1)'(fire);
   end

   // NOTE: memory arrays carry no reset; their contents survive reset by design.
   always_ff @(posedge clock) begin
      if (state == IDLE && prog_we)
         prog_mem[prog_addr] <= prog_data;
      if (state == IDLE && exp_we)
         exp_mem[exp_addr] <= exp_data;
      if (lmem_we)
         lmem[fa] <= wdata;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         ip          <= '0;
         steps       <= '0;
         outpos      <= '0;
         exp_count_q <= '0;
         mismatch    <= 1'b0;
         error       <= ERR_NONE;
         finished    <= 1'b0;
         success     <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
`ifdef BRANCH_STATS_EN
         branches_taken <= '0;
`endif
      end else begin
         if (fire) begin
            out_valid <= 1'b1;
            out_data  <= emit_val;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= RUN;
                  ip          <= '0;
                  steps       <= '0;
                  outpos      <= '0;
                  exp_count_q <= exp_count;
                  mismatch    <= 1'b0;
                  error       <= ERR_NONE;
                  finished    <= 1'b0;
                  success     <= 1'b0;
`ifdef BRANCH_STATS_EN
                  branches_taken <= '0;
`endif
               end
            end
            RUN: begin
               steps    <= steps + 32'(stepped);
               ip       <= ip_n;
               outpos   <= outpos_n;
               mismatch <= mismatch_n;
`ifdef BRANCH_STATS_EN
               if (stepped && bu_taken)
                  branches_taken <= branches_taken + 32'd1;
`endif
               if (go_done) begin
                  state    <= DONE;
                  finished <= 1'b1;
                  error    <= err_n;
                  success  <= (err_n == ERR_NONE) && !mismatch_n && (outpos_n == exp_count_q);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
